// File: rtl/button_pkg.sv
// Shared types and default timing constants for the pushbutton input path.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  localparam int CLK_HZ              = 20000000;
  localparam int DEBOUNCE_CYCLES_DEF = 200000;
  localparam int LONG_CYCLES_DEF     = 20000000;

endpackage

// File: rtl/button_reader_sync.sv
// Two-flop synchroniser for asynchronous board inputs; RESET_VAL sets the idle level.
module sync_2ff #(
  parameter int         WIDTH     = 1,
  parameter logic [0:0] RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= {WIDTH{RESET_VAL}};
      sync2_q <= {WIDTH{RESET_VAL}};
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/button_reader.sv
// Debounced pushbutton reader: level, press/release/long-press strobes,
// press counter and a press-toggled LED drive.
module button_reader
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count,
  output logic       led
);

  localparam int DEB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;

  // The sample that moves the FSM out of IDLE/HELD already counts as the
  // first stable sample, so the wait states finish after DEBOUNCE_CYCLES-1 more.
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic        btn_sync_n;
  logic        s;

  btn_state_t        state_q,         state_d;
  logic [DEB_W-1:0]  deb_cnt_q,       deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q,      hold_cnt_d;
  logic              long_done_q,     long_done_d;
  logic              btn_level_q,     btn_level_d;
  logic              press_pulse_q,   press_pulse_d;
  logic              release_pulse_q, release_pulse_d;
  logic              long_pulse_q,    long_pulse_d;
  logic [7:0]        press_count_q,   press_count_d;
  logic              led_q,           led_d;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_n),
    .q     (btn_sync_n)
  );

  assign s = ~btn_sync_n;

  always_comb begin
    state_d         = state_q;
    deb_cnt_d       = deb_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    long_done_d     = long_done_q;
    btn_level_d     = btn_level_q;
    press_count_d   = press_count_q;
    led_d           = led_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_pulse_d    = 1'b0;

    // Hold time keeps running through a release bounce so long-press timing is unaffected.
    if (state_q == HELD || state_q == RELEASE_WAIT) begin
      if (hold_cnt_q != HOLD_LAST) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end else if (!long_done_q) begin
        long_pulse_d = 1'b1;
        long_done_d  = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (s) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d       = HELD;
          press_pulse_d = 1'b1;
          btn_level_d   = 1'b1;
          press_count_d = press_count_q + 8'd1;
          led_d         = ~led_q;
          hold_cnt_d    = '0;
          long_done_d   = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_d   = RELEASE_WAIT;
          deb_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = HELD;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d         = IDLE;
          release_pulse_d = 1'b1;
          btn_level_d     = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      deb_cnt_q       <= '0;
      hold_cnt_q      <= '0;
      long_done_q     <= 1'b0;
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      press_count_q   <= 8'd0;
      led_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      deb_cnt_q       <= deb_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      long_done_q     <= long_done_d;
      btn_level_q     <= btn_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
      press_count_q   <= press_count_d;
      led_q           <= led_d;
    end
  end

  assign btn_level     = btn_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_pulse    = long_pulse_q;
  assign press_count   = press_count_q;
  assign led           = led_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
module tb_button_reader;

  localparam int DEB  = 4;
  localparam int LONG = 16;
  localparam int LAT  = DEB + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_n = 1'b1;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;
  logic       led;

  int n_checks = 0;
  int n_fail   = 0;

  button_reader #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_n         (btn_n),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .press_count   (press_count),
    .led           (led)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_press(input string tag);
    btn_n = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      step();
      check_val({tag, "_press_pulse"}, press_pulse, (i == LAT));
    end
    check_val({tag, "_level"}, btn_level, 1);
  endtask

  task automatic expect_release(input string tag);
    btn_n = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      step();
      check_val({tag, "_release_pulse"}, release_pulse, (i == LAT));
    end
    check_val({tag, "_level"}, btn_level, 0);
  endtask

  initial begin
    // Reset held with the button down
    rst_n = 1'b0;
    btn_n = 1'b0;
    repeat (3) step();
    check_val("rst_level", btn_level, 0);
    check_val("rst_press", press_pulse, 0);
    check_val("rst_release", release_pulse, 0);
    check_val("rst_long", long_pulse, 0);
    check_val("rst_count", press_count, 0);
    check_val("rst_led", led, 0);
    $display("txn reset: outputs cleared");

    rst_n = 1'b1;
    expect_press("rst_exit");
    check_val("rst_exit_count", press_count, 1);
    check_val("rst_exit_led", led, 1);
    $display("txn press after reset: count=%0d led=%0d", press_count, led);

    // Long press: single strobe 16 edges after press_pulse
    for (int k = 1; k <= 30; k++) begin
      step();
      check_val("long_pulse", long_pulse, (k == LONG));
      check_val("long_level", btn_level, 1);
    end
    expect_release("long_rel");
    $display("txn long press + release");

    // Clean press, then a 2-cycle release glitch while held
    btn_n = 1'b1;
    repeat (3) step();
    expect_press("clean");
    check_val("clean_count", press_count, 2);
    check_val("clean_led", led, 0);
    $display("txn clean press: count=%0d", press_count);

    for (int k = 1; k <= 25; k++) begin
      btn_n = (k == 4 || k == 5) ? 1'b0 : 1'b0;
      if (k == 3 || k == 4) btn_n = 1'b1;
      step();
      check_val("glitch_release", release_pulse, 0);
      check_val("glitch_level", btn_level, 1);
      check_val("glitch_long", long_pulse, (k == LONG));
    end
    expect_release("glitch_rel");
    $display("txn release glitch rejected, long timing kept");

    // Press bounce: low 2, high 1, then steady low
    repeat (3) step();
    btn_n = 1'b0;
    step();
    check_val("bounce_p1", press_pulse, 0);
    step();
    check_val("bounce_p2", press_pulse, 0);
    btn_n = 1'b1;
    step();
    check_val("bounce_p3", press_pulse, 0);
    expect_press("bounce");
    check_val("bounce_count", press_count, 3);
    check_val("bounce_led", led, 1);
    expect_release("bounce_rel");
    $display("txn bounced press: count=%0d", press_count);

    // Wrap: 253 presses reach 256 total, then 3 more
    for (int n = 1; n <= 256; n++) begin
      btn_n = 1'b0;
      repeat (LAT) step();
      btn_n = 1'b1;
      repeat (LAT) step();
      if (n == 253) begin
        check_val("wrap_count0", press_count, 0);
        check_val("wrap_led0", led, 0);
        $display("txn wrap: count=%0d led=%0d", press_count, led);
      end
    end
    check_val("wrap_count3", press_count, 3);
    check_val("wrap_led3", led, 1);
    $display("txn wrap+3: count=%0d led=%0d", press_count, led);

    // Reset while held
    expect_press("mid");
    rst_n = 1'b0;
    step();
    check_val("mid_rst_level", btn_level, 0);
    check_val("mid_rst_count", press_count, 0);
    check_val("mid_rst_led", led, 0);
    $display("txn reset while held");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
